alu_seq_param: RTL and testbench

- Parametrised, multi-cycle signed ALU: the next generation of the team's 8-bit sequential ALU.
- Operands stream in word-by-word on a shared input bus; results stream out word-by-word on a shared output bus.
- Supports add, sub, radix-2 Booth multiply (2W-bit product) and non-restoring divide (2W-bit dividend, W-bit divisor).
- Adds status flags, Busy/End handshake and divide-by-zero handling, none of which the previous block has.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_addsub.sv | 27 ++
 rtl/alu_seq_param.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_seq_param.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential signed ALU: op codes, FSM states, flag bit positions.
// Latency: none (declarations only).
// Backpressure: none.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD0  = 3'd1,
    LD1  = 3'd2,
    LD2  = 3'd3,
    EXEC = 3'd4,
    OUT0 = 3'd5,
    OUT1 = 3'd6,
    DONE = 3'd7
  } state_t;

  localparam int FLG_CARRY = 0;
  localparam int FLG_OVF   = 1;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_NEG   = 3;

endpackage

// File: rtl/alu_seq_addsub.sv
// Shared WIDTH+1-bit adder/subtractor used by add/sub, Booth and non-restoring divide paths.
// Latency: combinational.
// Backpressure: none; carry/ovf describe the low WIDTH bits as a WIDTH-bit signed operation.
module alu_seq_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           carry,
  output logic           ovf
);

  logic [WIDTH:0] b_eff;
  logic [WIDTH:0] lo;

  // Subtraction is a + ~b + 1; the low-word sum gives the WIDTH-bit carry (no-borrow on sub).
  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = a + b_eff + {{WIDTH{1'b0}}, sub};
    lo    = {1'b0, a[WIDTH-1:0]} + {1'b0, b_eff[WIDTH-1:0]} + {{WIDTH{1'b0}}, sub};
    carry = lo[WIDTH];
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (lo[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_seq_param.sv
// Multi-cycle signed ALU (add/sub/Booth mul/non-restoring div), word-serial operands and results.
// Latency: add/sub 1, mul WIDTH, div WIDTH+1 (div-by-zero 1) EXEC cycles after last operand word.
// Backpressure: Begin ignored while busy; DONE holds End=1 until Begin is low. Macro ALU_SAT_EN enables saturation.
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLk,
  input  logic             RST_n,
  input  logic             Begin,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             Busy,
  output logic             End,
  output logic [3:0]       flags
);

`ifdef ALU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0]   MAX_S  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MIN_S  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] w0, w1, sec;
  logic [WIDTH:0]   acc, m;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CNT_W-1:0] cnt;
  logic             dvd_neg, dvs_neg, div_big, div_zero;

  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             add_sub, add_carry, add_ovf;

  logic [WIDTH:0]   booth_a, acc_nx;
  logic [WIDTH-1:0] q_nx;
  logic             q1_nx;
  logic             fin;
  logic [WIDTH-1:0] prim, secw, rem_mag;
  logic [3:0]       flg;
  logic             q_neg, q_ovf;

  logic [2*WIDTH-1:0] dvd, dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;

  alu_seq_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (add_a),
    .b     (add_b),
    .sub   (add_sub),
    .sum   (add_sum),
    .carry (add_carry),
    .ovf   (add_ovf)
  );

  // Operand magnitudes for the divider, formed while the divisor word is on the bus.
  always_comb begin
    dvd     = {w0, w1};
    dvd_mag = w0[WIDTH-1] ? (~dvd + ONE_2W) : dvd;
    dvs_mag = inbus[WIDTH-1] ? (~inbus + ONE_W) : inbus;
  end

  // EXEC datapath: steers the shared adder and forms next-state and result words.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    booth_a = acc;
    acc_nx  = acc;
    q_nx    = q;
    q1_nx   = q_1;
    fin     = 1'b0;
    prim    = '0;
    secw    = '0;
    flg     = '0;
    rem_mag = '0;
    q_neg   = 1'b0;
    q_ovf   = 1'b0;
    if (state == EXEC) begin
      case (op_r)
        OP_ADD, OP_SUB: begin
          add_a   = {w0[WIDTH-1], w0};
          add_b   = {w1[WIDTH-1], w1};
          add_sub = (op_r == OP_SUB);
          fin     = 1'b1;
          prim    = add_sum[WIDTH-1:0];
          // Overflow direction follows the sign of A for both add and sub.
          if (SAT_EN && add_ovf) prim = w0[WIDTH-1] ? MIN_S : MAX_S;
          flg[FLG_CARRY] = add_carry;
          flg[FLG_OVF]   = add_ovf;
          flg[FLG_NEG]   = prim[WIDTH-1];
          flg[FLG_ZERO]  = (prim == '0);
          secw[3:0]      = flg;
        end
        OP_MUL: begin
          // One Booth step: Q0,Q-1 = 01 adds M, 10 subtracts M, then arithmetic shift right.
          add_a   = acc;
          add_b   = m;
          add_sub = q[0] & ~q_1;
          booth_a = (q[0] ^ q_1) ? add_sum : acc;
          acc_nx  = {booth_a[WIDTH], booth_a[WIDTH:1]};
          q_nx    = {booth_a[0], q[WIDTH-1:1]};
          q1_nx   = q[0];
          if (cnt == CNT_W'(1)) begin
            fin           = 1'b1;
            prim          = acc_nx[WIDTH-1:0];
            secw          = q_nx;
            flg[FLG_NEG]  = acc_nx[WIDTH-1];
            flg[FLG_ZERO] = ({acc_nx[WIDTH-1:0], q_nx} == '0);
          end
        end
        default: begin
          if (div_zero) begin
            fin          = 1'b1;
            prim         = '1;
            secw         = w1;
            flg[FLG_OVF] = 1'b1;
            flg[FLG_NEG] = 1'b1;
          end else if (cnt != '0) begin
            // Non-restoring step on magnitudes; partial remainder wraps safely in WIDTH+1 bits.
            add_a   = {acc[WIDTH-1:0], q[WIDTH-1]};
            add_b   = m;
            add_sub = ~acc[WIDTH];
            acc_nx  = add_sum;
            q_nx    = {q[WIDTH-2:0], ~add_sum[WIDTH]};
          end else begin
            // Remainder correction, then sign fix-up of quotient and remainder.
            add_a   = acc;
            add_b   = m;
            add_sub = 1'b0;
            rem_mag = acc[WIDTH] ? add_sum[WIDTH-1:0] : acc[WIDTH-1:0];
            q_neg   = dvd_neg ^ dvs_neg;
            q_ovf   = div_big | (q_neg ? (q > MIN_S) : q[WIDTH-1]);
            prim    = q_neg ? (~q + ONE_W) : q;
            if (SAT_EN && q_ovf) prim = q_neg ? MIN_S : MAX_S;
            secw    = dvd_neg ? (~rem_mag + ONE_W) : rem_mag;
            fin     = 1'b1;
            flg[FLG_OVF]  = q_ovf;
            flg[FLG_NEG]  = prim[WIDTH-1];
            flg[FLG_ZERO] = (prim == '0);
          end
        end
      endcase
    end
  end

  // Control FSM, operand/shift registers and registered outputs.
  always_ff @(posedge CLk) begin
    if (!RST_n) begin
      state    <= IDLE;
      op_r     <= '0;
      w0       <= '0;
      w1       <= '0;
      sec      <= '0;
      acc      <= '0;
      m        <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      cnt      <= '0;
      dvd_neg  <= 1'b0;
      dvs_neg  <= 1'b0;
      div_big  <= 1'b0;
      div_zero <= 1'b0;
      outbus   <= '0;
      flags    <= '0;
      End      <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Begin) begin
            op_r  <= op;
            w0    <= inbus;
            Busy  <= 1'b1;
            state <= LD1;
          end
        end
        LD0: begin
          w0    <= inbus;
          state <= LD1;
        end
        LD1: begin
          w1  <= inbus;
          cnt <= CNT_W'(WIDTH);
          if (op_r == OP_DIV) begin
            state <= LD2;
          end else begin
            acc   <= '0;
            q     <= inbus;
            q_1   <= 1'b0;
            m     <= {w0[WIDTH-1], w0};
            state <= EXEC;
          end
        end
        LD2: begin
          acc      <= {1'b0, dvd_mag[2*WIDTH-1:WIDTH]};
          q        <= dvd_mag[WIDTH-1:0];
          m        <= {1'b0, dvs_mag};
          dvd_neg  <= w0[WIDTH-1];
          dvs_neg  <= inbus[WIDTH-1];
          div_zero <= (inbus == '0);
          div_big  <= (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag);
          state    <= EXEC;
        end
        EXEC: begin
          acc <= acc_nx;
          q   <= q_nx;
          q_1 <= q1_nx;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          if (fin) begin
            outbus <= prim;
            sec    <= secw;
            flags  <= flg;
            End    <= 1'b1;
            state  <= OUT0;
          end
        end
        OUT0: begin
          outbus <= sec;
          state  <= OUT1;
        end
        OUT1: state <= DONE;
        DONE: begin
          if (!Begin) begin
            End   <= 1'b0;
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param at WIDTH=8 with hand-computed vectors.
// Latency: checks EXEC-to-End cycle counts per operation.
// Backpressure: exercises Begin held through DONE and release to IDLE.
module tb_alu_seq_param;

  logic       CLk   = 1'b0;
  logic       RST_n = 1'b0;
  logic       Begin = 1'b0;
  logic [1:0] op    = 2'd0;
  logic [7:0] inbus = 8'd0;
  logic [7:0] outbus;
  logic       Busy;
  logic       End;
  logic [3:0] flags;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_param #(.WIDTH(8)) dut (
    .CLk    (CLk),
    .RST_n  (RST_n),
    .Begin  (Begin),
    .op     (op),
    .inbus  (inbus),
    .outbus (outbus),
    .Busy   (Busy),
    .End    (End),
    .flags  (flags)
  );

  always #5 CLk = ~CLk;

  task automatic tick();
    @(posedge CLk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full transaction: load words, wait for End, check both result words, flags and release.
  task automatic do_op(input string nm, input logic [1:0] o,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] e0, input logic [7:0] e1,
                       input logic [3:0] ef, input int elat);
    int n;
    Begin = 1'b1; op = o; inbus = a;
    tick();
    Begin = 1'b0; op = ~o;
    check({nm, ".busy"}, 32'(Busy), 32'd1);
    inbus = b;
    tick();
    if (o == 2'd3) begin
      inbus = c;
      tick();
    end
    inbus = 8'hA5;
    n = 0;
    while (End !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({nm, ".lat"},   32'(n),      32'(elat));
    check({nm, ".out0"},  32'(outbus), 32'(e0));
    check({nm, ".flags"}, 32'(flags),  32'(ef));
    tick();
    check({nm, ".out1"},  32'(outbus), 32'(e1));
    check({nm, ".end1"},  32'(End),    32'd1);
    tick();
    check({nm, ".done"},  32'(End),    32'd1);
    tick();
    check({nm, ".idle"},  32'({End, Busy}), 32'd0);
    check({nm, ".hold"},  32'(outbus), 32'(e1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst.out",   32'(outbus), 32'd0);
    check("rst.flags", 32'(flags),  32'd0);
    check("rst.endbusy", 32'({End, Busy}), 32'd0);
    RST_n = 1'b1;
    tick();

    do_op("add1", 2'd0, 8'd24,  8'd31,  8'd0, 8'h37, 8'h00, 4'b0000, 1);
    do_op("add2", 2'd0, 8'd200, 8'd75,  8'd0, 8'h13, 8'h01, 4'b0001, 1);
`ifdef ALU_SAT_EN
    do_op("subov", 2'd1, 8'h80, 8'h01,  8'd0, 8'h80, 8'h0B, 4'b1011, 1);
`else
    do_op("subov", 2'd1, 8'h80, 8'h01,  8'd0, 8'h7F, 8'h03, 4'b0011, 1);
`endif
    do_op("subz", 2'd1, 8'd5,   8'd5,   8'd0, 8'h00, 8'h05, 4'b0101, 1);
    do_op("mul1", 2'd2, 8'd32,  8'hE7,  8'd0, 8'hFC, 8'hE0, 4'b1000, 8);
    do_op("mul2", 2'd2, 8'hE0,  8'hE7,  8'd0, 8'h03, 8'h20, 4'b0000, 8);
    do_op("mul3", 2'd2, 8'h80,  8'h80,  8'd0, 8'h40, 8'h00, 4'b0000, 8);
    do_op("div1", 2'd3, 8'h09,  8'h60,  8'd20, 8'd120, 8'h00, 4'b0000, 9);
`ifdef ALU_SAT_EN
    do_op("divov", 2'd3, 8'h00, 8'h80,  8'd1, 8'h7F, 8'h00, 4'b0010, 9);
`else
    do_op("divov", 2'd3, 8'h00, 8'h80,  8'd1, 8'h80, 8'h00, 4'b1010, 9);
`endif
    do_op("div0", 2'd3, 8'hFF,  8'h9C,  8'd0, 8'hFF, 8'h9C, 4'b1010, 1);
    do_op("div2", 2'd3, 8'hFF,  8'h9C,  8'd7, 8'hF2, 8'hFE, 4'b1000, 9);

    // Mid-multiply reset: outbus currently holds 0xFE from the last divide.
    Begin = 1'b1; op = 2'd2; inbus = 8'd32;
    tick();
    Begin = 1'b0; inbus = 8'hE7;
    tick();
    tick();
    tick();
    RST_n = 1'b0;
    tick();
    RST_n = 1'b1;
    check("rstmul.out",     32'(outbus), 32'd0);
    check("rstmul.flags",   32'(flags),  32'd0);
    check("rstmul.endbusy", 32'({End, Busy}), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("rstmul.quiet", 32'({End, Busy}), 32'd0);
    do_op("add56", 2'd0, 8'd5, 8'd6, 8'd0, 8'd11, 8'h00, 4'b0000, 1);

    // Begin held high through DONE: no restart until released.
    Begin = 1'b1; op = 2'd0; inbus = 8'd1;
    tick();
    inbus = 8'd2;
    tick();
    tick();
    check("hs.out0", 32'(outbus), 32'd3);
    tick();
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("hs.held", 32'({End, Busy}), 32'd3);
    check("hs.word", 32'(outbus), 32'd0);
    Begin = 1'b0;
    tick();
    check("hs.rel", 32'({End, Busy}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
